// File: rtl/arb_merge_pkg.sv
// Shared types and helpers for the N-channel arbitrating merge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: arb_mode_t arbitration policy, id_width() source-index width helper.
package arb_merge_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,  // round-robin from a rotating pointer
    ARB_FIXED = 1'b1   // lowest channel index always wins
  } arb_mode_t;

  // Width of a channel index; never below one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mrg_fifo.sv
// Synchronous per-channel FIFO with registered occupancy count.
// Latency: a word written at edge t is visible on head in the cycle after t.
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: clk/rst (sync, active-high), push/push_data, pop,
//        full/empty/count status, head = oldest stored word.
module mrg_fifo #(
  parameter int D_WIDTH = 6,
  parameter int A_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [D_WIDTH-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [A_WIDTH:0]   count,
  output logic [D_WIDTH-1:0] head
);

  localparam int DEPTH = 2 ** A_WIDTH;

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == (A_WIDTH + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH; count disambiguates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (A_WIDTH + 1)'(push_ok) - (A_WIDTH + 1)'(pop_ok);
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/arb_merge_n.sv
// Merges N_CH valid/ready channels into one stream tagged with source index.
// Latency: 1 cycle from upstream push to downstream presentation; no pass-through.
// Backpressure: grant locks while down_valid & !down_ready; up_ready from FIFO count only.
// Ports: clk/rst (sync, active-high), up_valid/up_ready/up_data per channel
//        (channel i at up_data[i*D_WIDTH +: D_WIDTH]), down_valid/down_ready/down_data/down_id.
module arb_merge_n
  import arb_merge_pkg::*;
#(
  parameter int        D_WIDTH = 6,
  parameter int        A_WIDTH = 2,
  parameter int        N_CH    = 4,
  parameter arb_mode_t MODE    = ARB_RR,
  localparam int       ID_W    = id_width(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         up_valid,
  output logic [N_CH-1:0]         up_ready,
  input  logic [N_CH*D_WIDTH-1:0] up_data,
  output logic                    down_valid,
  input  logic                    down_ready,
  output logic [D_WIDTH-1:0]      down_data,
  output logic [ID_W-1:0]         down_id
);

  localparam int DEPTH = 2 ** A_WIDTH;

  logic [N_CH-1:0]    push;
  logic [N_CH-1:0]    pop;
  logic [N_CH-1:0]    full;
  logic [N_CH-1:0]    empty;
  logic [N_CH-1:0]    nonempty;
  logic [A_WIDTH:0]   count [N_CH];
  logic [D_WIDTH-1:0] head  [N_CH];

  logic [ID_W-1:0] rr_ptr;
  logic            lock;
  logic [ID_W-1:0] gnt_q;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] idx;
  logic            found;
  logic [ID_W-1:0] grant;
  logic            take;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mrg_fifo #(
      .D_WIDTH (D_WIDTH),
      .A_WIDTH (A_WIDTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (up_data[i*D_WIDTH +: D_WIDTH]),
      .pop       (pop[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .count     (count[i]),
      .head      (head[i])
    );

    // Ready is a pure function of registered occupancy; the rst term keeps
    // words offered during reset from looking accepted.
    assign up_ready[i] = ~rst & (count[i] != (A_WIDTH + 1)'(DEPTH));
    assign push[i]     = up_valid[i] & ~full[i] & ~rst;
    assign pop[i]      = take & (grant == ID_W'(i));
    assign nonempty[i] = ~empty[i];
  end

  // Search order starts at rr_ptr (round-robin) or at 0 (fixed priority).
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (MODE == ARB_FIXED) idx = ID_W'(k);
      else                   idx = ID_W'((int'(rr_ptr) + k) % N_CH);
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // A stalled word keeps its grant so data/id stay stable until accepted.
  assign grant      = lock ? gnt_q : pick;
  assign down_valid = (|nonempty) & ~rst;
  assign take       = down_valid & down_ready;
  assign down_id    = down_valid ? grant : '0;
  assign down_data  = down_valid ? head[grant] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock   <= 1'b0;
      gnt_q  <= '0;
      rr_ptr <= '0;
    end else begin
      if (down_valid && !down_ready) begin
        lock  <= 1'b1;
        gnt_q <= grant;
      end else if (take) begin
        lock  <= 1'b0;
      end
      if (take && MODE == ARB_RR) begin
        rr_ptr <= (grant == ID_W'(N_CH - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arb_merge_n.sv
// Bench for arb_merge_n: one round-robin and one fixed-priority instance.
// Stimulus pushes hand-computed expected {id,data} into per-instance queues;
// negedge monitors pop and compare on every downstream handshake.
module tb_arb_merge_n;
  import arb_merge_pkg::*;

  localparam int DW = 6;
  localparam int AW = 2;
  localparam int NC = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [NC-1:0]    up_valid, up_ready;
  logic [NC*DW-1:0] up_data;
  logic             down_valid, down_ready;
  logic [DW-1:0]    down_data;
  logic [IW-1:0]    down_id;

  logic [NC-1:0]    f_up_valid, f_up_ready;
  logic [NC*DW-1:0] f_up_data;
  logic             f_down_valid, f_down_ready;
  logic [DW-1:0]    f_down_data;
  logic [IW-1:0]    f_down_id;

  arb_merge_n #(.D_WIDTH(DW), .A_WIDTH(AW), .N_CH(NC), .MODE(ARB_RR)) u_rr (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .down_valid(down_valid), .down_ready(down_ready),
    .down_data(down_data), .down_id(down_id)
  );

  arb_merge_n #(.D_WIDTH(DW), .A_WIDTH(AW), .N_CH(NC), .MODE(ARB_FIXED)) u_fx (
    .clk(clk), .rst(rst),
    .up_valid(f_up_valid), .up_ready(f_up_ready), .up_data(f_up_data),
    .down_valid(f_down_valid), .down_ready(f_down_ready),
    .down_data(f_down_data), .down_id(f_down_id)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fx[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int id, input int d);
    exp_t e;
    e.id  = IW'(id);
    e.dat = DW'(d);
    return e;
  endfunction

  always @(negedge clk) begin : mon_rr
    exp_t e;
    if (!rst && down_valid && down_ready) begin
      check("rr_pending", 32'(q_rr.size() > 0), 1);
      if (q_rr.size() > 0) begin
        e = q_rr.pop_front();
        check("rr_id", 32'(down_id), 32'(e.id));
        check("rr_data", 32'(down_data), 32'(e.dat));
      end
    end
  end

  always @(negedge clk) begin : mon_fx
    exp_t e;
    if (!rst && f_down_valid && f_down_ready) begin
      check("fx_pending", 32'(q_fx.size() > 0), 1);
      if (q_fx.size() > 0) begin
        e = q_fx.pop_front();
        check("fx_id", 32'(f_down_id), 32'(e.id));
        check("fx_data", 32'(f_down_data), 32'(e.dat));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_up(input int ch, input logic v, input int d);
    up_valid[ch]          = v;
    up_data[ch*DW +: DW]  = DW'(d);
  endtask

  task automatic set_fx(input int ch, input logic v, input int d);
    f_up_valid[ch]         = v;
    f_up_data[ch*DW +: DW] = DW'(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Bounded wait for a queue to empty, then confirm the output went idle.
  task automatic drain(input string name, input bit fx);
    for (int i = 0; i < 40; i++) begin
      if ((fx ? q_fx.size() : q_rr.size()) == 0) break;
      tick();
    end
    check(name, 32'(fx ? q_fx.size() : q_rr.size()), 0);
    @(negedge clk);
    check({name, "_idle"}, 32'(fx ? f_down_valid : down_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst          = 1'b1;
    up_valid     = '0;
    up_data      = '0;
    down_ready   = 1'b0;
    f_up_valid   = '0;
    f_up_data    = '0;
    f_down_ready = 1'b1;

    // Reset state, during and after reset
    tick();
    tick();
    @(negedge clk);
    check("rst_down_valid", 32'(down_valid), 0);
    check("rst_down_id", 32'(down_id), 0);
    check("rst_down_data", 32'(down_data), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_up_ready", 32'(up_ready), 32'hF);
    check("post_rst_fx_up_ready", 32'(f_up_ready), 32'hF);
    check("post_rst_down_valid", 32'(down_valid), 0);

    // Single channel, one-cycle latency
    tick();
    down_ready = 1'b1;
    q_rr.push_back(mk(2, 'h05));
    q_rr.push_back(mk(2, 'h06));
    set_up(2, 1'b1, 'h05);
    @(negedge clk);
    check("t1_no_passthru", 32'(down_valid), 0);
    tick();
    set_up(2, 1'b1, 'h06);
    @(negedge clk);
    check("t1_lat_valid", 32'(down_valid), 1);
    check("t1_lat_id", 32'(down_id), 2);
    check("t1_lat_data", 32'(down_data), 'h05);
    tick();
    set_up(2, 1'b0, 0);
    drain("t1_drain", 1'b0);

    // Full FIFO holds off the fifth word until a pop
    tick();
    down_ready = 1'b0;
    for (int k = 0; k < 5; k++) q_rr.push_back(mk(0, 'h20 + k));
    for (int k = 0; k < 4; k++) begin
      set_up(0, 1'b1, 'h20 + k);
      tick();
    end
    set_up(0, 1'b1, 'h24);
    @(negedge clk);
    check("t2_full_ready", 32'(up_ready[0]), 0);
    tick();
    tick();
    @(negedge clk);
    check("t2_held_ready", 32'(up_ready[0]), 0);
    check("t2_head_id", 32'(down_id), 0);
    check("t2_head_data", 32'(down_data), 'h20);
    tick();
    down_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ok = up_ready[0];
      tick();
      if (ok) break;
    end
    check("t2_fifth_accepted", 32'(ok), 1);
    set_up(0, 1'b0, 0);
    drain("t2_drain", 1'b0);

    // Round-robin fairness, two words per channel
    tick();
    do_reset();
    down_ready = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NC; c++) q_rr.push_back(mk(c, c * 'h10 + k));
    up_valid = 4'hF;
    up_data  = {6'h30, 6'h20, 6'h10, 6'h00};
    tick();
    up_data  = {6'h31, 6'h21, 6'h11, 6'h01};
    tick();
    up_valid = '0;
    @(negedge clk);
    check("t3_first_id", 32'(down_id), 0);
    tick();
    down_ready = 1'b1;
    drain("t3_drain", 1'b0);

    // Grant lock under backpressure while ch0 fills
    tick();
    do_reset();
    down_ready = 1'b0;
    q_rr.push_back(mk(1, 'h11));
    q_rr.push_back(mk(0, 'h01));
    q_rr.push_back(mk(0, 'h02));
    q_rr.push_back(mk(0, 'h03));
    set_up(1, 1'b1, 'h11);
    tick();
    set_up(1, 1'b0, 0);
    set_up(0, 1'b1, 'h01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_lock_id", 32'(down_id), 1);
      check("t4_lock_data", 32'(down_data), 'h11);
      tick();
      if (k < 2) set_up(0, 1'b1, k + 2);
      else       set_up(0, 1'b0, 0);
    end
    down_ready = 1'b1;
    drain("t4_drain", 1'b0);

    // Fixed priority: ch0 overtakes remaining ch3 words after the lock releases
    tick();
    q_fx.push_back(mk(3, 'h30));
    q_fx.push_back(mk(3, 'h31));
    q_fx.push_back(mk(0, 'h01));
    q_fx.push_back(mk(0, 'h02));
    q_fx.push_back(mk(3, 'h32));
    q_fx.push_back(mk(3, 'h33));
    f_down_ready = 1'b1;
    set_fx(3, 1'b1, 'h30);
    tick();
    set_fx(3, 1'b1, 'h31);
    tick();
    set_fx(3, 1'b1, 'h32);
    set_fx(0, 1'b1, 'h01);
    f_down_ready = 1'b0;
    @(negedge clk);
    check("t5_stall_id", 32'(f_down_id), 3);
    check("t5_stall_data", 32'(f_down_data), 'h31);
    tick();
    set_fx(3, 1'b1, 'h33);
    set_fx(0, 1'b1, 'h02);
    @(negedge clk);
    check("t5_lock_id", 32'(f_down_id), 3);
    check("t5_lock_data", 32'(f_down_data), 'h31);
    tick();
    set_fx(3, 1'b0, 0);
    set_fx(0, 1'b0, 0);
    f_down_ready = 1'b1;
    drain("t5_drain", 1'b1);

    // Mid-operation reset discards buffered words
    tick();
    down_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_up(0, 1'b1, 'h2A + k);
      tick();
    end
    set_up(0, 1'b0, 0);
    @(negedge clk);
    check("t6_pre_valid", 32'(down_valid), 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t6_in_rst_valid", 32'(down_valid), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_valid", 32'(down_valid), 0);
    check("t6_post_id", 32'(down_id), 0);
    check("t6_post_data", 32'(down_data), 0);
    check("t6_post_ready", 32'(up_ready), 32'hF);
    tick();
    down_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_idle_valid", 32'(down_valid), 0);
      tick();
    end
    q_rr.push_back(mk(0, 'h15));
    set_up(0, 1'b1, 'h15);
    tick();
    set_up(0, 1'b0, 0);
    drain("t6_drain", 1'b0);

    check("final_rr_queue", 32'(q_rr.size()), 0);
    check("final_fx_queue", 32'(q_fx.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/arb_merge_n.md
ARB_MERGE_N -- requirements
Module: arb_merge_n

Interface
REQ-001 SHALL have parameter D_WIDTH, default 6, meaning payload width per word.
REQ-002 SHALL have parameter A_WIDTH, default 2, meaning per-channel FIFO depth = 2**A_WIDTH words.
REQ-003 SHALL have parameter N_CH, default 4, range 2..16, meaning number of upstream channels.
REQ-004 SHALL have parameter MODE, default ARB_RR, meaning arbitration policy (ARB_RR round-robin, ARB_FIXED lowest index wins).
REQ-005 SHALL derive localparam ID_W = max(1, clog2(N_CH)).
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port up_valid, input, N_CH, per-channel valid.
REQ-009 SHALL have port up_ready, output, N_CH, per-channel ready.
REQ-010 SHALL have port up_data, input, N_CH*D_WIDTH, channel i in bits [i*D_WIDTH +: D_WIDTH].
REQ-011 SHALL have port down_valid, output, 1, merged valid.
REQ-012 SHALL have port down_ready, input, 1, merged ready.
REQ-013 SHALL have port down_data, output, D_WIDTH, merged payload, unmodified.
REQ-014 SHALL have port down_id, output, ID_W, source channel index of down_data.

Function
REQ-015 SHALL push channel i word when up_valid[i] & up_ready[i] at a rising edge; pop granted word when down_valid & down_ready.
REQ-016 SHALL drive up_ready[i] = (count[i] != DEPTH) from registered count only, no combinational path from down_ready or up_valid.
REQ-017 SHALL, on simultaneous push and pop of the same channel, leave count unchanged and preserve order.
REQ-018 SHALL give latency of exactly 1 cycle: word pushed at edge t is presentable on down_* in cycle after t; no same-cycle pass-through.
REQ-019 SHALL drive down_valid = 1 whenever any FIFO is non-empty; down_data/down_id = head and index of granted channel.
REQ-020 SHALL lock grant while down_valid & !down_ready; down_data and down_id SHALL hold stable until the pop.
REQ-021 SHALL in ARB_RR grant first non-empty channel at or after pointer rr_ptr (wrapping N_CH-1 -> 0); on pop SHALL set rr_ptr = granted+1 mod N_CH.
REQ-022 SHALL in ARB_FIXED grant lowest-index non-empty channel when unlocked; rr_ptr unused.
REQ-023 SHALL keep FIFO pointers A_WIDTH bits wrapping naturally, count A_WIDTH+1 bits, 0..DEPTH.
REQ-024 SHALL keep per-channel word order; no word dropped or duplicated.

Reset
REQ-025 SHALL on rst clear all counts/pointers, rr_ptr = 0, grant lock = 0, regardless of ongoing traffic.
REQ-026 SHALL during and the cycle after rst drive down_valid = 0, down_id = 0, down_data = 0, up_ready = all ones after rst deasserts (all ones from first cycle with rst low).
REQ-027 SHALL discard FIFO contents on mid-operation reset; no partial word emitted afterward.

Structure
REQ-028 SHALL place arb_mode_t enum (ARB_RR, ARB_FIXED) and id-width function in package arb_merge_pkg.
REQ-029 SHALL instantiate N_CH copies of sub-module mrg_fifo (sync FIFO, push/pop/full/empty/count/head) via generate.
REQ-030 SHALL keep arbiter, lock and rr_ptr in arb_merge_n top.

Verification
REQ-031 Single channel: ch2 sends 0x05,0x06, down_ready=1 -> down_id=2, data 0x05 then 0x06, first valid 1 cycle after push.
REQ-032 Full: ch0 sends 5 words, down_ready=0 -> up_ready[0]=0 after 4th push; 5th held until a pop, then accepted.
REQ-033 RR fairness: all 4 channels hold 2 words each, down_ready=1 -> down_id sequence 0,1,2,3,0,1,2,3.
REQ-034 Fixed priority: MODE=ARB_FIXED, ch3 valid from t0, ch0 valid from t2 -> ch0 words precede remaining ch3 words after lock release.
REQ-035 Backpressure lock: ch1 head 0x11 presented, down_ready=0 for 3 cycles while ch0 fills -> down_id=1, down_data=0x11 stable all 3 cycles.
REQ-036 Mid-reset: rst pulsed with 3 words in ch0 -> down_valid=0 next cycle, count 0, no 0x stale word ever emitted; scoreboard per-channel model matches throughout.
